// File: rtl/decoder_pkg.sv
// Shared MIPS decode encodings: opcodes, funct codes and the control-field
// encodings consumed by the ALU, PC-select and write-back muxes.
package decoder_pkg;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_J     = 6'h02;
    localparam logic [5:0] OPC_JAL   = 6'h03;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_BNE   = 6'h05;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_XORI  = 6'h0E;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;

    localparam logic [5:0] FUNCT_JR  = 6'h08;
    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    localparam logic [4:0] LINK_REG  = 5'd31;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_XOR = 3'd2,
        ALU_SLT = 3'd3
    } alu_op_e;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'd0,
        PC_JUMP   = 2'd1,
        PC_REG    = 2'd2,
        PC_BRANCH = 2'd3
    } pc_src_e;

    typedef enum logic [1:0] {
        WB_RESULT = 2'd0,
        WB_LINK   = 2'd1
    } wb_sel_e;

    typedef struct packed {
        alu_op_e op;
        pc_src_e pc_src;
        wb_sel_e wb_sel;
        logic    reg_we;
        logic    dm_we;
        logic    alu_b_imm;
        logic    bne;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '{
        op:        ALU_ADD,
        pc_src:    PC_PLUS4,
        wb_sel:    WB_RESULT,
        reg_we:    1'b0,
        dm_we:     1'b0,
        alu_b_imm: 1'b0,
        bne:       1'b0
    };

    function automatic logic [31:0] extend_imm(input logic [15:0] imm16, input logic zero_ext);
        return zero_ext ? {16'h0000, imm16} : {{16{imm16[15]}}, imm16};
    endfunction

endpackage

// File: rtl/decoder.sv
// Single-stage MIPS instruction decoder: combinational decode of instr
// feeding one output register bank, one result per clock.
module decoder
    import decoder_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    output logic [25:0] jAddr,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  regWAddr,
    output logic [31:0] imm,
    output logic [2:0]  op,
    output logic [1:0]  pcSrcCtrl,
    output logic [1:0]  regDInCtrl,
    output logic        regWe,
    output logic        dmWe,
    output logic        aluBSrcCtrl,
    output logic        bneCtrl
);

    logic [5:0]  opcode;
    logic [5:0]  funct;
    ctrl_t       ctrl_nxt;
    logic [4:0]  waddr_nxt;
    logic [31:0] imm_nxt;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];

    // Control depends only on opcode/funct; anything unrecognised stays NOP.
    always_comb begin
        ctrl_nxt = CTRL_NOP;
        case (opcode)
            OPC_LW: begin
                ctrl_nxt.reg_we    = 1'b1;
                ctrl_nxt.alu_b_imm = 1'b1;
            end
            OPC_SW: begin
                ctrl_nxt.alu_b_imm = 1'b1;
                ctrl_nxt.dm_we     = 1'b1;
            end
            OPC_J: begin
                ctrl_nxt.pc_src    = PC_JUMP;
                ctrl_nxt.alu_b_imm = 1'b1;
            end
            OPC_JAL: begin
                ctrl_nxt.pc_src    = PC_JUMP;
                ctrl_nxt.reg_we    = 1'b1;
                ctrl_nxt.alu_b_imm = 1'b1;
                ctrl_nxt.wb_sel    = WB_LINK;
            end
            OPC_BEQ: begin
                ctrl_nxt.op        = ALU_SUB;
                ctrl_nxt.pc_src    = PC_BRANCH;
                ctrl_nxt.alu_b_imm = 1'b1;
            end
            OPC_BNE: begin
                ctrl_nxt.op        = ALU_SUB;
                ctrl_nxt.pc_src    = PC_BRANCH;
                ctrl_nxt.alu_b_imm = 1'b1;
                ctrl_nxt.bne       = 1'b1;
            end
            OPC_XORI: begin
                ctrl_nxt.op        = ALU_XOR;
                ctrl_nxt.reg_we    = 1'b1;
                ctrl_nxt.alu_b_imm = 1'b1;
            end
            OPC_ADDI: begin
                ctrl_nxt.reg_we    = 1'b1;
                ctrl_nxt.alu_b_imm = 1'b1;
            end
            OPC_RTYPE: begin
                case (funct)
                    FUNCT_JR:  ctrl_nxt.pc_src = PC_REG;
                    FUNCT_ADD: ctrl_nxt.reg_we = 1'b1;
                    FUNCT_SUB: begin
                        ctrl_nxt.op     = ALU_SUB;
                        ctrl_nxt.reg_we = 1'b1;
                    end
                    FUNCT_SLT: begin
                        ctrl_nxt.op     = ALU_SLT;
                        ctrl_nxt.reg_we = 1'b1;
                    end
                    default: ctrl_nxt = CTRL_NOP;
                endcase
            end
            default: ctrl_nxt = CTRL_NOP;
        endcase
    end

    // Write address follows the instruction format even for unknown functs.
    always_comb begin
        if (opcode == OPC_RTYPE) begin
            waddr_nxt = instr[15:11];
        end else if (opcode == OPC_JAL) begin
            waddr_nxt = LINK_REG;
        end else begin
            waddr_nxt = instr[20:16];
        end
    end

    assign imm_nxt = extend_imm(instr[15:0], opcode == OPC_XORI);

    always_ff @(posedge clk) begin
        if (reset) begin
            jAddr       <= '0;
            rs          <= '0;
            rt          <= '0;
            rd          <= '0;
            regWAddr    <= '0;
            imm         <= '0;
            op          <= '0;
            pcSrcCtrl   <= '0;
            regDInCtrl  <= '0;
            regWe       <= 1'b0;
            dmWe        <= 1'b0;
            aluBSrcCtrl <= 1'b0;
            bneCtrl     <= 1'b0;
        end else begin
            jAddr       <= instr[25:0];
            rs          <= instr[25:21];
            rt          <= instr[20:16];
            rd          <= instr[15:11];
            regWAddr    <= waddr_nxt;
            imm         <= imm_nxt;
            op          <= ctrl_nxt.op;
            pcSrcCtrl   <= ctrl_nxt.pc_src;
            regDInCtrl  <= ctrl_nxt.wb_sel;
            regWe       <= ctrl_nxt.reg_we;
            dmWe        <= ctrl_nxt.dm_we;
            aluBSrcCtrl <= ctrl_nxt.alu_b_imm;
            bneCtrl     <= ctrl_nxt.bne;
        end
    end

endmodule

// File: tb/tb_decoder.sv
// Scoreboard bench for decoder: expected outputs queued when an instruction
// is driven, compared one clock later.
module tb_decoder;

    logic        clk;
    logic        reset;
    logic [31:0] instr;
    logic [25:0] jAddr;
    logic [4:0]  rs, rt, rd, regWAddr;
    logic [31:0] imm;
    logic [2:0]  op;
    logic [1:0]  pcSrcCtrl, regDInCtrl;
    logic        regWe, dmWe, aluBSrcCtrl, bneCtrl;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [25:0] jaddr;
        logic [4:0]  rs, rt, rd, waddr;
        logic [31:0] imm;
        logic [2:0]  op;
        logic [1:0]  pc;
        logic        we, alub, dm, bne;
        logic [1:0]  rdin;
    } exp_t;

    exp_t exp_q[$];

    decoder dut (
        .clk         (clk),
        .reset       (reset),
        .instr       (instr),
        .jAddr       (jAddr),
        .rs          (rs),
        .rt          (rt),
        .rd          (rd),
        .regWAddr    (regWAddr),
        .imm         (imm),
        .op          (op),
        .pcSrcCtrl   (pcSrcCtrl),
        .regDInCtrl  (regDInCtrl),
        .regWe       (regWe),
        .dmWe        (dmWe),
        .aluBSrcCtrl (aluBSrcCtrl),
        .bneCtrl     (bneCtrl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic exp_t set_ctl(input exp_t e, input int o, input int pc, input int we,
                                     input int ab, input int dm, input int bn, input int rdin);
        exp_t r = e;
        r.op   = 3'(o);
        r.pc   = 2'(pc);
        r.we   = 1'(we);
        r.alub = 1'(ab);
        r.dm   = 1'(dm);
        r.bne  = 1'(bn);
        r.rdin = 2'(rdin);
        return r;
    endfunction

    function automatic exp_t model(input logic [31:0] i, input logic r);
        exp_t e = '0;
        logic [5:0] opc = i[31:26];
        if (r) return e;
        e.jaddr = i[25:0];
        e.rs    = i[25:21];
        e.rt    = i[20:16];
        e.rd    = i[15:11];
        e.imm   = (opc == 6'h0E) ? {16'h0000, i[15:0]} : {{16{i[15]}}, i[15:0]};
        e.waddr = (opc == 6'h00) ? i[15:11] : (opc == 6'h03) ? 5'd31 : i[20:16];
        case (opc)
            6'h23: e = set_ctl(e, 0, 0, 1, 1, 0, 0, 0);
            6'h2B: e = set_ctl(e, 0, 0, 0, 1, 1, 0, 0);
            6'h02: e = set_ctl(e, 0, 1, 0, 1, 0, 0, 0);
            6'h03: e = set_ctl(e, 0, 1, 1, 1, 0, 0, 1);
            6'h04: e = set_ctl(e, 1, 3, 0, 1, 0, 0, 0);
            6'h05: e = set_ctl(e, 1, 3, 0, 1, 0, 1, 0);
            6'h0E: e = set_ctl(e, 2, 0, 1, 1, 0, 0, 0);
            6'h08: e = set_ctl(e, 0, 0, 1, 1, 0, 0, 0);
            6'h00: begin
                case (i[5:0])
                    6'h08: e = set_ctl(e, 0, 2, 0, 0, 0, 0, 0);
                    6'h20: e = set_ctl(e, 0, 0, 1, 0, 0, 0, 0);
                    6'h22: e = set_ctl(e, 1, 0, 1, 0, 0, 0, 0);
                    6'h2A: e = set_ctl(e, 3, 0, 1, 0, 0, 0, 0);
                    default: ;
                endcase
            end
            default: ;
        endcase
        return e;
    endfunction

    task automatic compare_out();
        exp_t e;
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        check("ctrl", 64'({op, pcSrcCtrl, regWe, aluBSrcCtrl, dmWe, bneCtrl, regDInCtrl}),
                      64'({e.op, e.pc, e.we, e.alub, e.dm, e.bne, e.rdin}));
        check("fields", 64'({jAddr, rs, rt, rd}), 64'({e.jaddr, e.rs, e.rt, e.rd}));
        check("waddr", 64'(regWAddr), 64'(e.waddr));
        check("imm", 64'(imm), 64'(e.imm));
    endtask

    // Compare the previous instruction's result, then drive the next one.
    task automatic step(input logic [31:0] i, input logic r);
        @(negedge clk);
        compare_out();
        reset = r;
        instr = i;
        exp_q.push_back(model(i, r));
    endtask

    logic [5:0] opc_list [12] = '{6'h23, 6'h2B, 6'h02, 6'h03, 6'h04, 6'h05,
                                  6'h0E, 6'h08, 6'h00, 6'h00, 6'h3F, 6'h11};
    logic [5:0] fn_list  [5]  = '{6'h08, 6'h20, 6'h22, 6'h2A, 6'h21};

    initial begin
        reset = 1'b1;
        instr = 32'h8C00_0000;

        step(32'h8C00_0000, 1'b1);
        step(32'h8C00_0000, 1'b1);
        step({6'h23, 26'd23342}, 1'b0);
        step({6'h03, 20'd29934, 6'h12}, 1'b0);
        step({6'h05, 20'd2291, 6'h01}, 1'b0);
        step({6'h00, 20'd34921, 6'h20}, 1'b0);
        step({6'h00, 20'd34921, 6'h22}, 1'b0);
        step({6'h00, 20'd34921, 6'h2A}, 1'b0);
        step({6'h00, 20'd34921, 6'h08}, 1'b0);
        step({6'h0E, 5'd3, 5'd7, 16'h8000}, 1'b0);
        step({6'h08, 5'd3, 5'd7, 16'h8000}, 1'b0);
        step(32'h0000_0000, 1'b0);
        step({6'h3F, 26'h3FF_FFFF}, 1'b0);
        step({6'h2B, 26'h155_5555}, 1'b0);
        step({6'h04, 26'h2AA_AAAA}, 1'b0);
        step({6'h02, 26'h123_4567}, 1'b0);
        step({6'h23, 26'h000_0001}, 1'b1);
        step({6'h00, 5'd1, 5'd2, 5'd3, 5'd4, 6'h2A}, 1'b0);

        for (int n = 0; n < 200; n++) begin
            logic [31:0] w;
            w = $urandom;
            w[31:26] = opc_list[$urandom_range(0, 11)];
            if (w[31:26] == 6'h00 && $urandom_range(0, 3) != 0)
                w[5:0] = fn_list[$urandom_range(0, 4)];
            step(w, (n == 97) ? 1'b1 : 1'b0);
        end

        @(negedge clk);
        compare_out();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
